// File: rtl/tmds_link_ctrl_pkg.sv
// Shared constants and helpers for the TMDS link bring-up sequencer.
package tmds_link_ctrl_pkg;

  // The lock-loss debug counter stops at this value.
  localparam logic [7:0] LOSS_CNT_MAX = 8'hFF;

  // Width of a counter that must hold values up to n.
  // Never returns 0, so a parameter of 0 still yields a legal 1-bit vector.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/xd_sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous level signal.
module xd_sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give the first stage a full cycle to resolve metastability.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tmds_link_ctrl.sv
// Bring-up and supervision sequencer for the TMDS output path.
// Waits for a stable clock lock, holds the serializers in reset, forces
// control symbols for a few frames, then lets encoder data through.
// Any lock loss outside IDLE drops the link back and is counted for debug.
module tmds_link_ctrl
  import tmds_link_ctrl_pkg::*;
#(
  parameter int LOCK_CYCLES   = 8,
  parameter int RST_CYCLES    = 16,
  parameter int SETTLE_FRAMES = 2
) (
  input  logic       clk_pix,
  input  logic       rst_pix_n,
  input  logic       clk_lock,
  input  logic       frame_start,
  output logic       ser_rst,
  output logic       ctrl_only,
  output logic       link_up,
  output logic [7:0] lock_loss_cnt
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RESET  = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam logic [1:0] ST_ACTIVE = 2'd3;

  localparam int LOCK_W = cnt_width(LOCK_CYCLES);
  localparam int RST_W  = cnt_width(RST_CYCLES);
  localparam int FRM_W  = cnt_width(SETTLE_FRAMES);

  // Terminal values: each counter is compared against its last value so
  // the transition happens on the N-th qualifying edge.
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES - 1);
  localparam logic [FRM_W-1:0]  FRM_LAST  =
    FRM_W'((SETTLE_FRAMES > 0) ? SETTLE_FRAMES - 1 : 0);

  logic              lock_s;
  logic [1:0]        state;
  logic [LOCK_W-1:0] lock_cnt;
  logic [RST_W-1:0]  rst_cnt;
  logic [FRM_W-1:0]  frm_cnt;

  xd_sync_2ff u_lock_sync (
    .clk   (clk_pix),
    .rst_n (rst_pix_n),
    .d     (clk_lock),
    .q     (lock_s)
  );

  // Sequencer, its three counters and outputs decoded from the state being entered.
  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      state         <= ST_IDLE;
      lock_cnt      <= '0;
      rst_cnt       <= '0;
      frm_cnt       <= '0;
      ser_rst       <= 1'b1;
      ctrl_only     <= 1'b1;
      link_up       <= 1'b0;
      lock_loss_cnt <= '0;
    end else if ((state != ST_IDLE) && !lock_s) begin
      state     <= ST_IDLE;
      lock_cnt  <= '0;
      rst_cnt   <= '0;
      frm_cnt   <= '0;
      ser_rst   <= 1'b1;
      ctrl_only <= 1'b1;
      link_up   <= 1'b0;
      if (lock_loss_cnt != LOSS_CNT_MAX) begin
        lock_loss_cnt <= lock_loss_cnt + 8'd1;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          ser_rst   <= 1'b1;
          ctrl_only <= 1'b1;
          link_up   <= 1'b0;
          if (lock_s) begin
            if (lock_cnt == LOCK_LAST) begin
              state    <= ST_RESET;
              lock_cnt <= '0;
            end else begin
              lock_cnt <= lock_cnt + 1'b1;
            end
          end else begin
            lock_cnt <= '0;
          end
        end

        ST_RESET: begin
          if (rst_cnt == RST_LAST) begin
            state     <= ST_SETTLE;
            rst_cnt   <= '0;
            ser_rst   <= 1'b0;
            ctrl_only <= 1'b1;
            link_up   <= 1'b0;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end

        ST_SETTLE: begin
          if (SETTLE_FRAMES == 0) begin
            state     <= ST_ACTIVE;
            ser_rst   <= 1'b0;
            ctrl_only <= 1'b0;
            link_up   <= 1'b1;
          end else if (frame_start) begin
            if (frm_cnt == FRM_LAST) begin
              state     <= ST_ACTIVE;
              frm_cnt   <= '0;
              ser_rst   <= 1'b0;
              ctrl_only <= 1'b0;
              link_up   <= 1'b1;
            end else begin
              frm_cnt <= frm_cnt + 1'b1;
            end
          end
        end

        ST_ACTIVE: begin
          ser_rst   <= 1'b0;
          ctrl_only <= 1'b0;
          link_up   <= 1'b1;
        end

        default: begin
          state     <= ST_IDLE;
          lock_cnt  <= '0;
          rst_cnt   <= '0;
          frm_cnt   <= '0;
          ser_rst   <= 1'b1;
          ctrl_only <= 1'b1;
          link_up   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tmds_link_ctrl.sv
// Directed testbench for tmds_link_ctrl: one default-parameter instance and
// one short-timing instance with SETTLE_FRAMES=0 used for saturation.
module tb_tmds_link_ctrl;

  logic       clk_pix = 1'b0;
  logic       rst_pix_n;
  logic       clk_lock_a, frame_start_a;
  logic       ser_rst_a, ctrl_only_a, link_up_a;
  logic [7:0] loss_cnt_a;
  logic       clk_lock_b, frame_start_b;
  logic       ser_rst_b, ctrl_only_b, link_up_b;
  logic [7:0] loss_cnt_b;

  int errors = 0;
  int checks = 0;

  always #5 clk_pix = ~clk_pix;

  tmds_link_ctrl #(.LOCK_CYCLES(8), .RST_CYCLES(16), .SETTLE_FRAMES(2)) dut_a (
    .clk_pix       (clk_pix),
    .rst_pix_n     (rst_pix_n),
    .clk_lock      (clk_lock_a),
    .frame_start   (frame_start_a),
    .ser_rst       (ser_rst_a),
    .ctrl_only     (ctrl_only_a),
    .link_up       (link_up_a),
    .lock_loss_cnt (loss_cnt_a)
  );

  tmds_link_ctrl #(.LOCK_CYCLES(2), .RST_CYCLES(3), .SETTLE_FRAMES(0)) dut_b (
    .clk_pix       (clk_pix),
    .rst_pix_n     (rst_pix_n),
    .clk_lock      (clk_lock_b),
    .frame_start   (frame_start_b),
    .ser_rst       (ser_rst_b),
    .ctrl_only     (ctrl_only_b),
    .link_up       (link_up_b),
    .lock_loss_cnt (loss_cnt_b)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk_pix);
  endtask

  task automatic do_reset();
    rst_pix_n     = 1'b0;
    clk_lock_a    = 1'b0;
    frame_start_a = 1'b0;
    clk_lock_b    = 1'b0;
    frame_start_b = 1'b0;
    step(2);
    rst_pix_n = 1'b1;
  endtask

  task automatic pulse_frame_a();
    frame_start_a = 1'b1;
    step(1);
    frame_start_a = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ser_rst_a !== 1'b1) begin errors++; $display("[TB] FAIL reset_ser_rst: got %b want 1", ser_rst_a); end
    checks++; if (ctrl_only_a !== 1'b1) begin errors++; $display("[TB] FAIL reset_ctrl_only: got %b want 1", ctrl_only_a); end
    checks++; if (link_up_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_link_up: got %b want 0", link_up_a); end
    checks++; if (loss_cnt_a !== 8'd0) begin errors++; $display("[TB] FAIL reset_loss_cnt: got %0d want 0", loss_cnt_a); end
    checks++; if (dut_a.state !== 2'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d want 0", dut_a.state); end
  endtask

  task automatic test_power_up();
    do_reset();
    clk_lock_a = 1'b1;
    step(9);
    checks++; if (dut_a.state !== 2'd0) begin errors++; $display("[TB] FAIL pu_idle_c9: got %0d want 0", dut_a.state); end
    step(1);
    checks++; if (dut_a.state !== 2'd1) begin errors++; $display("[TB] FAIL pu_reset_c10: got %0d want 1", dut_a.state); end
    checks++; if (ser_rst_a !== 1'b1) begin errors++; $display("[TB] FAIL pu_ser_rst_c10: got %b want 1", ser_rst_a); end
    step(15);
    checks++; if (ser_rst_a !== 1'b1) begin errors++; $display("[TB] FAIL pu_ser_rst_c25: got %b want 1", ser_rst_a); end
    step(1);
    checks++; if (ser_rst_a !== 1'b0) begin errors++; $display("[TB] FAIL pu_ser_rst_c26: got %b want 0", ser_rst_a); end
    checks++; if (ctrl_only_a !== 1'b1) begin errors++; $display("[TB] FAIL pu_ctrl_settle: got %b want 1", ctrl_only_a); end
    pulse_frame_a();
    checks++; if (link_up_a !== 1'b0) begin errors++; $display("[TB] FAIL pu_link_frame1: got %b want 0", link_up_a); end
    step(3);
    pulse_frame_a();
    checks++; if (link_up_a !== 1'b1) begin errors++; $display("[TB] FAIL pu_link_frame2: got %b want 1", link_up_a); end
    checks++; if (ctrl_only_a !== 1'b0) begin errors++; $display("[TB] FAIL pu_ctrl_active: got %b want 0", ctrl_only_a); end
    checks++; if (ser_rst_a !== 1'b0) begin errors++; $display("[TB] FAIL pu_ser_rst_active: got %b want 0", ser_rst_a); end
    checks++; if (loss_cnt_a !== 8'd0) begin errors++; $display("[TB] FAIL pu_loss_cnt: got %0d want 0", loss_cnt_a); end
  endtask

  // Continues from ACTIVE left by test_power_up.
  task automatic test_lock_loss_active();
    clk_lock_a = 1'b0;
    step(2);
    checks++; if (link_up_a !== 1'b1) begin errors++; $display("[TB] FAIL loss_link_edge2: got %b want 1", link_up_a); end
    step(1);
    checks++; if (link_up_a !== 1'b0) begin errors++; $display("[TB] FAIL loss_link_edge3: got %b want 0", link_up_a); end
    checks++; if (ser_rst_a !== 1'b1) begin errors++; $display("[TB] FAIL loss_ser_rst: got %b want 1", ser_rst_a); end
    checks++; if (ctrl_only_a !== 1'b1) begin errors++; $display("[TB] FAIL loss_ctrl_only: got %b want 1", ctrl_only_a); end
    checks++; if (loss_cnt_a !== 8'd1) begin errors++; $display("[TB] FAIL loss_cnt_inc: got %0d want 1", loss_cnt_a); end
    // Relock: full sequence again; a frame pulse on the SETTLE entry edge is ignored.
    clk_lock_a = 1'b1;
    step(25);
    checks++; if (ser_rst_a !== 1'b1) begin errors++; $display("[TB] FAIL relock_ser_rst_c25: got %b want 1", ser_rst_a); end
    pulse_frame_a();
    checks++; if (ser_rst_a !== 1'b0) begin errors++; $display("[TB] FAIL relock_ser_rst_c26: got %b want 0", ser_rst_a); end
    step(2);
    pulse_frame_a();
    checks++; if (link_up_a !== 1'b0) begin errors++; $display("[TB] FAIL relock_entry_pulse_counted: got %b want 0", link_up_a); end
    step(2);
    pulse_frame_a();
    checks++; if (link_up_a !== 1'b1) begin errors++; $display("[TB] FAIL relock_link_up: got %b want 1", link_up_a); end
    checks++; if (loss_cnt_a !== 8'd1) begin errors++; $display("[TB] FAIL relock_loss_cnt: got %0d want 1", loss_cnt_a); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    clk_lock_a = 1'b1;
    step(26);
    pulse_frame_a();
    step(2);
    clk_lock_a = 1'b0;
    step(2);
    pulse_frame_a();
    checks++; if (dut_a.state !== 2'd0) begin errors++; $display("[TB] FAIL simul_state: got %0d want 0", dut_a.state); end
    checks++; if (link_up_a !== 1'b0) begin errors++; $display("[TB] FAIL simul_link_up: got %b want 0", link_up_a); end
    checks++; if (ser_rst_a !== 1'b1) begin errors++; $display("[TB] FAIL simul_ser_rst: got %b want 1", ser_rst_a); end
    checks++; if (loss_cnt_a !== 8'd1) begin errors++; $display("[TB] FAIL simul_loss_cnt: got %0d want 1", loss_cnt_a); end
    step(1);
    checks++; if (link_up_a !== 1'b0) begin errors++; $display("[TB] FAIL simul_link_after: got %b want 0", link_up_a); end
  endtask

  task automatic test_glitch_idle();
    do_reset();
    clk_lock_a = 1'b1;
    step(5);
    clk_lock_a = 1'b0;
    step(1);
    clk_lock_a = 1'b1;
    step(9);
    checks++; if (dut_a.state !== 2'd0) begin errors++; $display("[TB] FAIL glitch_idle_c9: got %0d want 0", dut_a.state); end
    step(1);
    checks++; if (dut_a.state !== 2'd1) begin errors++; $display("[TB] FAIL glitch_reset_c10: got %0d want 1", dut_a.state); end
    checks++; if (loss_cnt_a !== 8'd0) begin errors++; $display("[TB] FAIL glitch_loss_cnt: got %0d want 0", loss_cnt_a); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    clk_lock_a = 1'b1;
    step(12);
    clk_lock_a = 1'b0;
    step(3);
    checks++; if (loss_cnt_a !== 8'd1) begin errors++; $display("[TB] FAIL rmid_loss_pre: got %0d want 1", loss_cnt_a); end
    clk_lock_a = 1'b1;
    step(13);
    rst_pix_n = 1'b0;
    step(1);
    rst_pix_n = 1'b1;
    checks++; if (dut_a.state !== 2'd0) begin errors++; $display("[TB] FAIL rmid_state: got %0d want 0", dut_a.state); end
    checks++; if (ser_rst_a !== 1'b1) begin errors++; $display("[TB] FAIL rmid_ser_rst: got %b want 1", ser_rst_a); end
    checks++; if (loss_cnt_a !== 8'd0) begin errors++; $display("[TB] FAIL rmid_loss_cleared: got %0d want 0", loss_cnt_a); end
    step(1);
    checks++; if (loss_cnt_a !== 8'd0) begin errors++; $display("[TB] FAIL rmid_loss_after: got %0d want 0", loss_cnt_a); end
  endtask

  task automatic test_settle_zero();
    do_reset();
    clk_lock_b = 1'b1;
    step(6);
    checks++; if (ser_rst_b !== 1'b1) begin errors++; $display("[TB] FAIL sz_ser_rst_c6: got %b want 1", ser_rst_b); end
    step(1);
    checks++; if (ser_rst_b !== 1'b0) begin errors++; $display("[TB] FAIL sz_ser_rst_c7: got %b want 0", ser_rst_b); end
    checks++; if (link_up_b !== 1'b0) begin errors++; $display("[TB] FAIL sz_link_c7: got %b want 0", link_up_b); end
    checks++; if (ctrl_only_b !== 1'b1) begin errors++; $display("[TB] FAIL sz_ctrl_c7: got %b want 1", ctrl_only_b); end
    step(1);
    checks++; if (link_up_b !== 1'b1) begin errors++; $display("[TB] FAIL sz_link_c8: got %b want 1", link_up_b); end
    checks++; if (ctrl_only_b !== 1'b0) begin errors++; $display("[TB] FAIL sz_ctrl_c8: got %b want 0", ctrl_only_b); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      clk_lock_b = 1'b1;
      step(5);
      clk_lock_b = 1'b0;
      step(4);
      if (i == 0) begin
        checks++; if (loss_cnt_b !== 8'd1) begin errors++; $display("[TB] FAIL sat_first: got %0d want 1", loss_cnt_b); end
      end
      if (i == 253) begin
        checks++; if (loss_cnt_b !== 8'd254) begin errors++; $display("[TB] FAIL sat_254: got %0d want 254", loss_cnt_b); end
      end
      if (i == 254) begin
        checks++; if (loss_cnt_b !== 8'd255) begin errors++; $display("[TB] FAIL sat_255: got %0d want 255", loss_cnt_b); end
      end
    end
    checks++; if (loss_cnt_b !== 8'd255) begin errors++; $display("[TB] FAIL sat_300: got %0d want 255", loss_cnt_b); end
  endtask

  initial begin
    rst_pix_n     = 1'b0;
    clk_lock_a    = 1'b0;
    frame_start_a = 1'b0;
    clk_lock_b    = 1'b0;
    frame_start_b = 1'b0;
    step(1);
    test_reset();
    test_power_up();
    test_lock_loss_active();
    test_simultaneous();
    test_glitch_idle();
    test_reset_mid();
    test_settle_zero();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
